// File: rtl/saxi_reg_responder.sv
// AXI4-Lite responder that turns AXI-Lite traffic into a single-beat register-file port.
// AW, W and AR each have a one-entry holding register. A single FSM serves one
// transaction at a time and alternates between writes and reads when both are pending.
module saxi_reg_responder #(
  parameter int unsigned S_AXI_TDATA_WIDTH = 64,
  parameter int unsigned S_AXI_ADDR_WIDTH  = 49,
  parameter logic [63:0] BASE_ADDR         = 64'h0000_0000,
  parameter int unsigned WIN_SIZE          = 12,
  parameter int unsigned READ_TIMEOUT      = 16
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_areset,
  // write address channel
  input  logic [S_AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  // write data channel
  input  logic [S_AXI_TDATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_TDATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  // write response channel
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  // read address channel
  input  logic [S_AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  // read data channel
  output logic [S_AXI_TDATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  // register-file port
  output logic                           reg_wr_en,
  output logic [WIN_SIZE-1:0]            reg_wr_addr,
  output logic [S_AXI_TDATA_WIDTH-1:0]   reg_wr_data,
  output logic [S_AXI_TDATA_WIDTH/8-1:0] reg_wr_strb,
  output logic                           reg_rd_en,
  output logic [WIN_SIZE-1:0]            reg_rd_addr,
  input  logic [S_AXI_TDATA_WIDTH-1:0]   reg_rd_data,
  input  logic                           reg_rd_valid
);

  localparam int unsigned StrbW = S_AXI_TDATA_WIDTH / 8;
  localparam int unsigned LsbW  = $clog2(StrbW);
  localparam logic [S_AXI_ADDR_WIDTH-1:0] BaseAddr = S_AXI_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [7:0] TimeoutLast = 8'(READ_TIMEOUT - 1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadWait,
    StWResp,
    StRResp
  } state_e;

  // Address is inside the window when all bits above the window size match the base.
  function automatic logic is_hit(input logic [S_AXI_ADDR_WIDTH-1:0] a);
    return a[S_AXI_ADDR_WIDTH-1:WIN_SIZE] == BaseAddr[S_AXI_ADDR_WIDTH-1:WIN_SIZE];
  endfunction

  // Byte offset inside the window, rounded down to a full data word.
  function automatic logic [WIN_SIZE-1:0] word_off(input logic [S_AXI_ADDR_WIDTH-1:0] a);
    logic [WIN_SIZE-1:0] o;
    o = a[WIN_SIZE-1:0];
    o[LsbW-1:0] = '0;
    return o;
  endfunction

  // Protection bits carry no meaning for this register window.
  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // Holding registers
  logic                          aw_full_q, aw_full_d;
  logic [S_AXI_ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic                          w_full_q, w_full_d;
  logic [S_AXI_TDATA_WIDTH-1:0]  w_data_q, w_data_d;
  logic [StrbW-1:0]              w_strb_q, w_strb_d;
  logic                          ar_full_q, ar_full_d;
  logic [S_AXI_ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic                          awready_q, wready_q, arready_q;

  // Service FSM and its output registers
  state_e                        state_q, state_d;
  logic                          last_wr_q, last_wr_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [WIN_SIZE-1:0]           wr_addr_q, wr_addr_d;
  logic [S_AXI_TDATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [StrbW-1:0]              wr_strb_q, wr_strb_d;
  logic [WIN_SIZE-1:0]           rd_addr_q, rd_addr_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [S_AXI_TDATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic grant_wr, grant_rd;
  logic aw_take, w_take, ar_take;

  assign aw_take = s_axi_awvalid & awready_q;
  assign w_take  = s_axi_wvalid & wready_q;
  assign ar_take = s_axi_arvalid & arready_q;

  // Holding-register next state: load on handshake, clear when the FSM consumes the entry.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    if (aw_take) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi_awaddr;
    end
    if (w_take) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end
    if (ar_take) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_axi_araddr;
    end
    // A take only happens while empty and a grant only while full, so these never collide.
    if (grant_wr) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (grant_rd) begin
      ar_full_d = 1'b0;
    end
  end

  // FSM next state: arbitration, decode and response generation.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    rd_addr_d = rd_addr_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Under contention the type not granted last wins; after reset that is the write.
        if (aw_full_q && w_full_q && (!ar_full_q || !last_wr_q)) begin
          grant_wr = 1'b1;
        end else if (ar_full_q) begin
          grant_rd = 1'b1;
        end

        if (grant_wr) begin
          last_wr_d = 1'b1;
          if (is_hit(aw_addr_q)) begin
            wr_addr_d = word_off(aw_addr_q);
            wr_data_d = w_data_q;
            wr_strb_d = w_strb_q;
            state_d   = StWrite;
          end else begin
            bresp_d = RespDecErr;
            state_d = StWResp;
          end
        end else if (grant_rd) begin
          last_wr_d = 1'b0;
          if (is_hit(ar_addr_q)) begin
            rd_addr_d = word_off(ar_addr_q);
            cnt_d     = '0;
            state_d   = StReadWait;
          end else begin
            rresp_d = RespDecErr;
            rdata_d = '0;
            state_d = StRResp;
          end
        end
      end

      StWrite: begin
        bresp_d = RespOkay;
        state_d = StWResp;
      end

      StReadWait: begin
        cnt_d = cnt_q + 8'd1;
        // Data cannot be valid in the strobe cycle itself, so only look from cycle 1 on.
        if (reg_rd_valid && (cnt_q != 8'd0)) begin
          rdata_d = reg_rd_data;
          rresp_d = RespOkay;
          state_d = StRResp;
        end else if (cnt_q == TimeoutLast) begin
          rdata_d = '0;
          rresp_d = RespSlvErr;
          state_d = StRResp;
        end
      end

      StWResp: begin
        if (s_axi_bready) begin
          state_d = StIdle;
        end
      end

      StRResp: begin
        if (s_axi_rready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; readies track the next-cycle empty flags.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      rd_addr_q <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      arready_q <= ~ar_full_d;
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      rd_addr_q <= rd_addr_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;

  assign s_axi_bvalid  = (state_q == StWResp);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (state_q == StRResp);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  assign reg_wr_en     = (state_q == StWrite);
  assign reg_wr_addr   = wr_addr_q;
  assign reg_wr_data   = wr_data_q;
  assign reg_wr_strb   = wr_strb_q;
  assign reg_rd_en     = (state_q == StReadWait) && (cnt_q == 8'd0);
  assign reg_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_saxi_reg_responder.sv
// Directed bench for saxi_reg_responder: a vector table of single transactions plus
// hand-written sequences for ordering, arbitration, backpressure and reset.
module tb_saxi_reg_responder;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 49;
  localparam int unsigned WS = 12;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_axi_areset;
  logic [AW-1:0] s_axi_awaddr;
  logic [2:0]    s_axi_awprot;
  logic          s_axi_awvalid, s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [7:0]    s_axi_wstrb;
  logic          s_axi_wvalid, s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid, s_axi_bready;
  logic [AW-1:0] s_axi_araddr;
  logic [2:0]    s_axi_arprot;
  logic          s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid, s_axi_rready;
  logic          reg_wr_en;
  logic [WS-1:0] reg_wr_addr;
  logic [DW-1:0] reg_wr_data;
  logic [7:0]    reg_wr_strb;
  logic          reg_rd_en;
  logic [WS-1:0] reg_rd_addr;
  logic [DW-1:0] reg_rd_data;
  logic          reg_rd_valid;

  saxi_reg_responder #(
    .S_AXI_TDATA_WIDTH(DW),
    .S_AXI_ADDR_WIDTH (AW),
    .BASE_ADDR        (64'h1000),
    .WIN_SIZE         (WS),
    .READ_TIMEOUT     (TO)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (s_axi_areset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awprot (s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arprot (s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_strb  (reg_wr_strb),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid)
  );

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;   // write data, or data the register model returns
    logic [7:0]    strb;
    int            lat;    // register model latency after reg_rd_en; 0 = never answers
    bit            hit;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    logic [WS-1:0] off;
  } vec_t;

  vec_t vecs[10];

  int n_vec, n_err;
  int cyc;
  int wr_cnt, rd_cnt, rbeat_cnt, rvalid_cnt;
  int wr_cyc, rd_cyc;
  logic [WS-1:0] wr_addr_s, rd_addr_s;
  logic [DW-1:0] wr_data_s;
  logic [7:0]    wr_strb_s;
  int            rm_lat, rm_fire;
  bit            rm_pend;
  logic [DW-1:0] rm_data;
  logic [WS:0]   op_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, run the register model and log strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    reg_rd_valid = 1'b0;
    if (rm_pend && cyc == rm_fire) begin
      reg_rd_valid = 1'b1;
      reg_rd_data  = rm_data;
      rm_pend      = 1'b0;
    end
    if (reg_wr_en) begin
      wr_cnt++;
      wr_cyc    = cyc;
      wr_addr_s = reg_wr_addr;
      wr_data_s = reg_wr_data;
      wr_strb_s = reg_wr_strb;
      op_log.push_back({1'b1, reg_wr_addr});
    end
    if (reg_rd_en) begin
      rd_cnt++;
      rd_cyc    = cyc;
      rd_addr_s = reg_rd_addr;
      op_log.push_back({1'b0, reg_rd_addr});
      if (rm_lat != 0) begin
        rm_pend = 1'b1;
        rm_fire = cyc + rm_lat;
      end
    end
    if (s_axi_rvalid) rvalid_cnt++;
    if (s_axi_rvalid && s_axi_rready) rbeat_cnt++;
  endtask

  task automatic run_write(input vec_t v, input int idx);
    int n0, w0, bcyc;
    logic [1:0] br;
    s_axi_bready = 1'b1;
    chk($sformatf("v%0d aw/w ready", idx), 64'(s_axi_awready & s_axi_wready), 64'd1);
    s_axi_awaddr  = v.addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = v.data;
    s_axi_wstrb   = v.strb;
    s_axi_wvalid  = 1'b1;
    n0 = cyc; w0 = wr_cnt; bcyc = -1; br = 2'b00;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    for (int i = 0; i < 12 && bcyc < 0; i++) begin
      if (s_axi_bvalid) begin
        bcyc = cyc;
        br   = s_axi_bresp;
      end
      tick();
    end
    chk($sformatf("v%0d wr strobes", idx), 64'(wr_cnt - w0), v.hit ? 64'd1 : 64'd0);
    if (v.hit) begin
      chk($sformatf("v%0d wr_en latency", idx), 64'(wr_cyc - n0), 64'd2);
      chk($sformatf("v%0d wr addr", idx), 64'(wr_addr_s), 64'(v.off));
      chk($sformatf("v%0d wr data", idx), wr_data_s, v.data);
      chk($sformatf("v%0d wr strb", idx), 64'(wr_strb_s), 64'(v.strb));
    end
    chk($sformatf("v%0d bvalid latency", idx), 64'(bcyc - n0), v.hit ? 64'd3 : 64'd2);
    chk($sformatf("v%0d bresp", idx), 64'(br), 64'(v.resp));
    chk($sformatf("v%0d bvalid drop", idx), 64'(s_axi_bvalid), 64'd0);
  endtask

  task automatic run_read(input vec_t v, input int idx);
    int n0, r0, b0, rcyc, exp_r;
    logic [1:0] rr;
    logic [DW-1:0] rd;
    rm_lat = v.lat;
    rm_data = v.data;
    s_axi_rready = 1'b1;
    chk($sformatf("v%0d arready", idx), 64'(s_axi_arready), 64'd1);
    s_axi_araddr  = v.addr;
    s_axi_arvalid = 1'b1;
    n0 = cyc; r0 = rd_cnt; b0 = rbeat_cnt; rcyc = -1; rr = 2'b00; rd = '0;
    tick();
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < int'(TO) + 12 && rcyc < 0; i++) begin
      if (s_axi_rvalid) begin
        rcyc = cyc;
        rr   = s_axi_rresp;
        rd   = s_axi_rdata;
      end
      tick();
    end
    chk($sformatf("v%0d rd strobes", idx), 64'(rd_cnt - r0), v.hit ? 64'd1 : 64'd0);
    if (v.hit) begin
      chk($sformatf("v%0d rd_en latency", idx), 64'(rd_cyc - n0), 64'd2);
      chk($sformatf("v%0d rd addr", idx), 64'(rd_addr_s), 64'(v.off));
      exp_r = (v.lat != 0) ? rd_cyc + v.lat + 1 : rd_cyc + int'(TO);
    end else begin
      exp_r = n0 + 2;
    end
    chk($sformatf("v%0d rvalid cycle", idx), 64'(rcyc), 64'(exp_r));
    chk($sformatf("v%0d rresp", idx), 64'(rr), 64'(v.resp));
    chk($sformatf("v%0d rdata", idx), rd, v.rdata);
    if (v.hit && v.lat == 0) begin
      // Late answer from the register file after the timeout must be dropped.
      tick();
      reg_rd_valid = 1'b1;
      reg_rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 0; i < 6; i++) tick();
      chk($sformatf("v%0d late valid strobes", idx), 64'(rd_cnt - r0), 64'd1);
    end
    chk($sformatf("v%0d r beats", idx), 64'(rbeat_cnt - b0), 64'd1);
  endtask

  initial begin
    int n0, wc, b0, r0, rv0, rcyc;
    bit p2w, p2r;
    logic [WS:0] exp_ops[4];

    vecs[0] = '{1'b1, 49'h1008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b1, 2'b00, 64'h0, 12'h008};
    vecs[1] = '{1'b0, 49'h1018, 64'h1234, 8'h00, 2, 1'b1, 2'b00, 64'h1234, 12'h018};
    vecs[2] = '{1'b1, 49'h3000, 64'h5555, 8'hFF, 0, 1'b0, 2'b11, 64'h0, 12'h000};
    vecs[3] = '{1'b0, 49'h0000, 64'h9999, 8'h00, 2, 1'b0, 2'b11, 64'h0, 12'h000};
    vecs[4] = '{1'b0, 49'h1020, 64'h0, 8'h00, 0, 1'b1, 2'b10, 64'h0, 12'h020};
    vecs[5] = '{1'b1, 49'h1FFF, 64'h01234567_89ABCDEF, 8'h0F, 0, 1'b1, 2'b00, 64'h0, 12'hFF8};
    vecs[6] = '{1'b0, 49'h1FFC, 64'hA5A55A5A_0F0FF0F0, 8'h00, 1, 1'b1, 2'b00,
                64'hA5A55A5A_0F0FF0F0, 12'hFF8};
    vecs[7] = '{1'b1, 49'h2000, 64'h6666, 8'h3C, 0, 1'b0, 2'b11, 64'h0, 12'h000};
    vecs[8] = '{0, 49'h0FFF, 64'h7777, 8'h00, 1, 1'b0, 2'b11, 64'h0, 12'h000};
    vecs[9] = '{1'b1, 49'h1_0000_0000_1008, 64'h8888, 8'hFF, 0, 1'b0, 2'b11, 64'h0, 12'h000};

    s_axi_areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    reg_rd_data = '0; reg_rd_valid = 1'b0;
    rm_lat = 0; rm_pend = 1'b0; rm_data = '0;

    // Reset values
    repeat (3) tick();
    chk("reset awready", 64'(s_axi_awready), 64'd0);
    chk("reset wready", 64'(s_axi_wready), 64'd0);
    chk("reset arready", 64'(s_axi_arready), 64'd0);
    chk("reset bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("reset rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("reset strobes", 64'({reg_wr_en, reg_rd_en}), 64'd0);
    chk("reset rdata", s_axi_rdata, 64'd0);
    chk("reset resps", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    chk("reset reg addrs", 64'({reg_wr_addr, reg_rd_addr}), 64'd0);
    s_axi_areset = 1'b0;
    tick();
    chk("readies after reset", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);

    // Arbitration: first contended grant is the write, the next one the read.
    op_log.delete();
    rm_lat = 1; rm_data = 64'h42;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    s_axi_awaddr = 49'h1100; s_axi_awvalid = 1'b1;
    s_axi_wdata = 64'h11; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 49'h1200; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    p2w = 1'b0; p2r = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      if (!p2w && s_axi_awready && s_axi_wready) begin
        s_axi_awaddr = 49'h1300; s_axi_awvalid = 1'b1;
        s_axi_wdata = 64'h33; s_axi_wvalid = 1'b1;
        p2w = 1'b1;
      end
      if (!p2r && s_axi_arready) begin
        s_axi_araddr = 49'h1400; s_axi_arvalid = 1'b1;
        p2r = 1'b1;
      end
    end
    exp_ops[0] = {1'b1, 12'h100};
    exp_ops[1] = {1'b0, 12'h200};
    exp_ops[2] = {1'b1, 12'h300};
    exp_ops[3] = {1'b0, 12'h400};
    chk("arb op count", 64'(op_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb op %0d", i), (i < op_log.size()) ? 64'(op_log[i]) : 64'h0,
          64'(exp_ops[i]));
    end

    // Table of single transactions
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) run_write(vecs[i], i);
      else run_read(vecs[i], i);
    end

    // W accepted three cycles before AW; wready stays low until the write is granted.
    s_axi_bready = 1'b1;
    s_axi_wdata = 64'h11112222_33334444; s_axi_wstrb = 8'hF0; s_axi_wvalid = 1'b1;
    chk("early w wready", 64'(s_axi_wready), 64'd1);
    wc = cyc;
    tick();
    s_axi_wvalid = 1'b0;
    chk("early w held 1", 64'(s_axi_wready), 64'd0);
    tick();
    chk("early w held 2", 64'(s_axi_wready), 64'd0);
    tick();
    chk("early w held 3", 64'(s_axi_wready), 64'd0);
    chk("early w awready", 64'(s_axi_awready), 64'd1);
    s_axi_awaddr = 49'h1010; s_axi_awvalid = 1'b1;
    n0 = cyc;
    tick();
    s_axi_awvalid = 1'b0;
    chk("late aw wready N+1", 64'(s_axi_wready), 64'd0);
    chk("late aw wr_en N+1", 64'(reg_wr_en), 64'd0);
    tick();
    chk("late aw wr_en N+2", 64'(reg_wr_en), 64'd1);
    chk("late aw wr addr", 64'(reg_wr_addr), 64'h010);
    chk("late aw wr data", reg_wr_data, 64'h11112222_33334444);
    chk("late aw wr strb", 64'(reg_wr_strb), 64'hF0);
    chk("late aw wready N+2", 64'(s_axi_wready), 64'd1);
    chk("late aw w lead", 64'(n0 - wc), 64'd3);
    tick();
    chk("late aw bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("late aw bresp", 64'(s_axi_bresp), 64'd0);
    tick();

    // Read backpressure with a second AR queued behind it.
    rm_lat = 2; rm_data = 64'h1234;
    s_axi_rready = 1'b0;
    s_axi_araddr = 49'h1018; s_axi_arvalid = 1'b1;
    n0 = cyc; r0 = rd_cnt;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    chk("bp rd_en", 64'(reg_rd_en), 64'd1);
    chk("bp arready free", 64'(s_axi_arready), 64'd1);
    s_axi_araddr = 49'h1028; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    chk("bp arready full", 64'(s_axi_arready), 64'd0);
    tick();
    tick();
    chk("bp rvalid", 64'(s_axi_rvalid), 64'd1);
    rm_data = 64'h5678;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp stall %0d rvalid", i), 64'(s_axi_rvalid), 64'd1);
      chk($sformatf("bp stall %0d rdata", i), s_axi_rdata, 64'h1234);
      chk($sformatf("bp stall %0d rresp", i), 64'(s_axi_rresp), 64'd0);
      chk($sformatf("bp stall %0d arready", i), 64'(s_axi_arready), 64'd0);
      tick();
    end
    s_axi_rready = 1'b1;
    tick();
    rcyc = -1;
    for (int i = 0; i < 30 && rcyc < 0; i++) begin
      if (s_axi_rvalid) begin
        rcyc = cyc;
        chk("bp second rdata", s_axi_rdata, 64'h5678);
      end
      tick();
    end
    chk("bp second rvalid cycle", 64'(rcyc - n0), 64'd15);
    chk("bp second rd addr", 64'(rd_addr_s), 64'h028);
    chk("bp rd strobes", 64'(rd_cnt - r0), 64'd2);

    // Reset while waiting for read data: the read is dropped for good.
    rm_lat = 0;
    s_axi_araddr = 49'h1018; s_axi_arvalid = 1'b1;
    r0 = rd_cnt; rv0 = rvalid_cnt; b0 = rbeat_cnt;
    tick();
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 10 && rd_cnt == r0; i++) tick();
    tick();
    tick();
    s_axi_areset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mid reset %0d readies", i),
          64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
      chk($sformatf("mid reset %0d rvalid", i), 64'(s_axi_rvalid), 64'd0);
    end
    s_axi_areset = 1'b0;
    tick();
    chk("post reset readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);
    for (int i = 0; i < 25; i++) tick();
    chk("post reset rvalid count", 64'(rvalid_cnt - rv0), 64'd0);
    chk("post reset r beats", 64'(rbeat_cnt - b0), 64'd0);
    chk("post reset rd strobes", 64'(rd_cnt - r0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
